tlb_assoc: RTL
==============

# tlb_assoc

Parametrised fully-associative MIPS32 TLB that succeeds the fixed 16-entry TLB in the MMU stage. It translates kuseg/kseg2/kseg3 addresses through ENTRIES programmable entries and passes kseg0/kseg1 through unmapped. It also implements the TLBWI/TLBWR/TLBP/TLBR datapaths, a hardware Random counter with Wired floor, and per-page dirty checking. Lookups, probes and reads return registered results one cycle after the request, so translation can sit in its own pipeline stage.

## Interface
- ENTRIES, 16, number of TLB entries (2..64); IDX_W = clog2(ENTRIES)
- ASID_W, 8, ASID width
- PFN_W, 20, physical frame number width
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- req_valid  in  1  translation request
- req_vaddr  in  32  virtual address
- req_store  in  1  request is a store
- cur_asid  in  ASID_W  current EntryHi.ASID
- resp_valid  out  1  response valid (request + 1 cycle)
- resp_paddr  out  32  physical address
- resp_miss / resp_invalid / resp_modified  out  1 each  refill, invalid, TLB-modified exception
- resp_multi  out  1  more than one entry matched
- sram_ce / flash_ce / rom_ce / serial_ce  out  1 each  device selects
- wr_en  in  1  write entry (TLBWI or TLBWR)
- wr_random  in  1  1 = use Random as the index, 0 = use wr_index
- wr_index  in  IDX_W  Index register value
- wr_vpn2  in  19  VPN2
- wr_asid  in  ASID_W  ASID
- wr_g  in  1  global bit
- wr_pfn0 / wr_pfn1  in  PFN_W  PFNs
- wr_dv0 / wr_dv1  in  2  {D,V} for even and odd page
- probe_req  in  1  TLBP, uses wr_vpn2/wr_asid
- probe_valid / probe_hit  out  1  probe result
- probe_index  out  IDX_W  matching index (0 on miss)
- rd_req  in  1  TLBR at wr_index
- rd_valid  out  1  read result valid
- rd_vpn2, rd_asid, rd_g, rd_pfn0, rd_pfn1, rd_dv0, rd_dv1  out  (matching widths)  entry contents
- wired_we  in  1  Wired register written
- wired  in  IDX_W  Wired value
- random  out  IDX_W  current Random

## Operation
- Match rule: entry.vpn2 == vaddr[31:13] and (entry.g or entry.asid == cur_asid). vaddr[12] selects odd (1) or even (0) page.
- Priority: lowest matching index wins. resp_multi is set when two or more entries match.
- Translation result on a match: paddr = {PFN, vaddr[11:0]}, truncated or zero-extended to 32 bits. sram_ce=1 when V=1.
- Exceptions on a mapped access:
  - no match: resp_miss=1
  - match with V=0: resp_invalid=1
  - store to a page with V=1, D=0: resp_modified=1
  - on any exception: paddr=0 and all CEs=0
- Unmapped kseg0 (0x80000000–0x9FFFFFFF): paddr = {1'b0, vaddr[30:0]}, sram_ce=1.
- Unmapped kseg1 (0xA0000000–0xBFFFFFFF): paddr = {3'b0, vaddr[28:0]}.
  - flash_ce for 0xBE000000–0xBEFFFFFF
  - rom_ce for 0xBFC00000–0xBFC00FFF
  - serial_ce for 0xBFD0F010 exactly
  - otherwise no CE
- Write: on wr_en, entry[wr_random ? random : wr_index] takes all wr_* fields at the clock edge. wr_index >= ENTRIES is ignored (no write).
- Random counter:
  - Decrements every cycle.
  - When random == wired, or random == 0, the next value is ENTRIES-1.
  - wired_we forces random = ENTRIES-1 next cycle.
  - A wired value >= ENTRIES is treated as ENTRIES-1.
- Probe: same match rule, using wr_asid in place of cur_asid and ignoring the page-select and V bits.
- Read: registered copy of entry[wr_index]. An out-of-range index returns all zeros.

## Timing
- Reset:
  - All entries cleared (vpn2=0, asid=0, g=0, V=D=0), so no entry can hit.
  - random = ENTRIES-1.
  - Every output 0.
- Lookup, probe and read latency is exactly 1 cycle. A new request may be issued every cycle (no backpressure).
- Response outputs are 0 whenever the corresponding valid is 0.
- A write and a lookup/probe/read in the same cycle: the lookup/probe/read sees the old contents. A request in the following cycle sees the new entry.
- TLBWR uses the value of random in the write cycle.
- Simultaneous wired_we and wr_random: the write uses the pre-reset random.
- Reset asserted mid-operation: the next edge clears everything, and valids drop in the cycle after.

## Test plan
- After reset: lookup at 0x00400000 -> resp_miss=1. Lookup at 0x80001234 -> paddr 0x00001234, sram_ce=1. Lookup at 0xBFD0F010 -> serial_ce=1, paddr 0x1FD0F010.
- TLBWI index 3 (vpn2=0x00200, asid=5, pfn0=0x12345 dv0=11, pfn1=0x54321 dv1=01), then:
  - lookup 0x00400ABC with asid 5 -> paddr 0x12345ABC
  - lookup 0x00401ABC as a store -> resp_modified=1
  - the same lookups with asid 6 -> resp_miss=1
  - the same lookups with asid 6 after rewriting the entry with g=1 -> hit
- With wired=4: random steps 15 down to 4, then wraps to 15. wired_we mid-count -> random=15 next cycle. TLBWR lands at the sampled random; confirm with TLBR.
- Write entry 7 and issue a lookup to the same VPN in the same cycle -> miss. The next-cycle lookup -> hit.
- Same VPN written at indices 2 and 9 -> index 2's PFN returned, resp_multi=1. TLBP on that VPN -> probe_hit=1, probe_index=2. TLBP on an absent VPN -> probe_hit=0.
- Assert rst during back-to-back lookups -> resp_valid=0 and all entries miss after reset. Repeat the whole bench with ENTRIES=8 and ENTRIES=32.

Source files
------------

// File: rtl/tlb_assoc.sv
// Fully-associative MIPS32 TLB: mapped/unmapped translation, TLBWI/TLBWR/TLBP/TLBR
// datapaths, Random counter with Wired floor. All results registered, 1-cycle latency.
module tlb_assoc #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned ASID_W  = 8,
  parameter int unsigned PFN_W   = 20,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [31:0]         req_vaddr,
  input  logic                req_store,
  input  logic [ASID_W-1:0]   cur_asid,
  output logic                resp_valid,
  output logic [31:0]         resp_paddr,
  output logic                resp_miss,
  output logic                resp_invalid,
  output logic                resp_modified,
  output logic                resp_multi,
  output logic                sram_ce,
  output logic                flash_ce,
  output logic                rom_ce,
  output logic                serial_ce,
  input  logic                wr_en,
  input  logic                wr_random,
  input  logic [IDX_W-1:0]    wr_index,
  input  logic [18:0]         wr_vpn2,
  input  logic [ASID_W-1:0]   wr_asid,
  input  logic                wr_g,
  input  logic [PFN_W-1:0]    wr_pfn0,
  input  logic [PFN_W-1:0]    wr_pfn1,
  input  logic [1:0]          wr_dv0,
  input  logic [1:0]          wr_dv1,
  input  logic                probe_req,
  output logic                probe_valid,
  output logic                probe_hit,
  output logic [IDX_W-1:0]    probe_index,
  input  logic                rd_req,
  output logic                rd_valid,
  output logic [18:0]         rd_vpn2,
  output logic [ASID_W-1:0]   rd_asid,
  output logic                rd_g,
  output logic [PFN_W-1:0]    rd_pfn0,
  output logic [PFN_W-1:0]    rd_pfn1,
  output logic [1:0]          rd_dv0,
  output logic [1:0]          rd_dv1,
  input  logic                wired_we,
  input  logic [IDX_W-1:0]    wired,
  output logic [IDX_W-1:0]    random
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  // Entry storage; e_used marks entries written since reset so cleared entries never match.
  logic [18:0]       e_vpn2 [ENTRIES];
  logic [ASID_W-1:0] e_asid [ENTRIES];
  logic              e_g    [ENTRIES];
  logic              e_used [ENTRIES];
  logic [PFN_W-1:0]  e_pfn0 [ENTRIES];
  logic [PFN_W-1:0]  e_pfn1 [ENTRIES];
  logic [1:0]        e_dv0  [ENTRIES];
  logic [1:0]        e_dv1  [ENTRIES];

  logic [IDX_W-1:0]  wired_q;
  logic [IDX_W-1:0]  wired_eff;
  logic [IDX_W-1:0]  rnd_next;

  logic              lk_hit, lk_multi;
  logic [IDX_W-1:0]  lk_idx;
  logic [PFN_W-1:0]  lk_pfn;
  logic [1:0]        lk_dv;

  logic              pr_hit;
  logic [IDX_W-1:0]  pr_idx;

  logic [IDX_W-1:0]  wr_sel;
  logic              wr_ok;
  logic              rd_ok;
  logic [IDX_W-1:0]  rd_sel;

  logic [31:0]       n_paddr;
  logic              n_miss, n_inv, n_mod, n_multi;
  logic              n_sram, n_flash, n_rom, n_ser;

  // Translation match: lowest matching index wins, flag any second match.
  always_comb begin
    lk_hit   = 1'b0;
    lk_multi = 1'b0;
    lk_idx   = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (e_used[i] && (e_vpn2[i] == req_vaddr[31:13]) &&
          (e_g[i] || (e_asid[i] == cur_asid))) begin
        if (lk_hit) begin
          lk_multi = 1'b1;
        end else begin
          lk_hit = 1'b1;
          lk_idx = IDX_W'(i);
        end
      end
    end
    lk_pfn = req_vaddr[12] ? e_pfn1[lk_idx] : e_pfn0[lk_idx];
    lk_dv  = req_vaddr[12] ? e_dv1[lk_idx]  : e_dv0[lk_idx];
  end

  // Probe match: same rule against wr_vpn2/wr_asid, page select and V ignored.
  always_comb begin
    pr_hit = 1'b0;
    pr_idx = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (!pr_hit && e_used[i] && (e_vpn2[i] == wr_vpn2) &&
          (e_g[i] || (e_asid[i] == wr_asid))) begin
        pr_hit = 1'b1;
        pr_idx = IDX_W'(i);
      end
    end
  end

  // Next translation result: kseg0/kseg1 bypass, otherwise mapped with exception checks.
  always_comb begin
    n_paddr = '0;
    n_miss  = 1'b0;
    n_inv   = 1'b0;
    n_mod   = 1'b0;
    n_multi = 1'b0;
    n_sram  = 1'b0;
    n_flash = 1'b0;
    n_rom   = 1'b0;
    n_ser   = 1'b0;
    if (req_vaddr[31:30] == 2'b10) begin
      if (!req_vaddr[29]) begin
        n_paddr = {1'b0, req_vaddr[30:0]};
        n_sram  = 1'b1;
      end else begin
        n_paddr = {3'b000, req_vaddr[28:0]};
        n_flash = (req_vaddr[31:24] == 8'hBE);
        n_rom   = (req_vaddr[31:12] == 20'hBFC00);
        n_ser   = (req_vaddr == 32'hBFD0_F010);
      end
    end else begin
      n_multi = lk_multi;
      if (!lk_hit) begin
        n_miss = 1'b1;
      end else if (!lk_dv[0]) begin
        n_inv = 1'b1;
      end else if (req_store && !lk_dv[1]) begin
        n_mod = 1'b1;
      end else begin
        n_paddr = 32'({lk_pfn, req_vaddr[11:0]});
        n_sram  = 1'b1;
      end
    end
  end

  // Write/read index selection and Random next-state (Wired clamped to ENTRIES-1).
  always_comb begin
    wr_sel    = wr_random ? random : wr_index;
    wr_ok     = wr_en && (wr_random || (32'(wr_index) < ENTRIES));
    rd_ok     = 32'(wr_index) < ENTRIES;
    rd_sel    = rd_ok ? wr_index : '0;
    wired_eff = (32'(wired_q) >= ENTRIES) ? LAST_IDX : wired_q;
    if (wired_we || (random == wired_eff) || (random == '0)) begin
      rnd_next = LAST_IDX;
    end else begin
      rnd_next = random - IDX_W'(1);
    end
  end

  // Entry array update on TLBWI/TLBWR.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (rst) begin
        e_vpn2[i] <= '0;
        e_asid[i] <= '0;
        e_g[i]    <= 1'b0;
        e_used[i] <= 1'b0;
        e_pfn0[i] <= '0;
        e_pfn1[i] <= '0;
        e_dv0[i]  <= '0;
        e_dv1[i]  <= '0;
      end else if (wr_ok && (wr_sel == IDX_W'(i))) begin
        e_vpn2[i] <= wr_vpn2;
        e_asid[i] <= wr_asid;
        e_g[i]    <= wr_g;
        e_used[i] <= 1'b1;
        e_pfn0[i] <= wr_pfn0;
        e_pfn1[i] <= wr_pfn1;
        e_dv0[i]  <= wr_dv0;
        e_dv1[i]  <= wr_dv1;
      end
    end
  end

  // Random and Wired registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      random  <= LAST_IDX;
      wired_q <= '0;
    end else begin
      random <= rnd_next;
      if (wired_we) begin
        wired_q <= wired;
      end
    end
  end

  // Registered lookup response, zero whenever no request was made.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid    <= 1'b0;
      resp_paddr    <= '0;
      resp_miss     <= 1'b0;
      resp_invalid  <= 1'b0;
      resp_modified <= 1'b0;
      resp_multi    <= 1'b0;
      sram_ce       <= 1'b0;
      flash_ce      <= 1'b0;
      rom_ce        <= 1'b0;
      serial_ce     <= 1'b0;
    end else begin
      resp_valid    <= req_valid;
      resp_paddr    <= req_valid ? n_paddr : '0;
      resp_miss     <= req_valid && n_miss;
      resp_invalid  <= req_valid && n_inv;
      resp_modified <= req_valid && n_mod;
      resp_multi    <= req_valid && n_multi;
      sram_ce       <= req_valid && n_sram;
      flash_ce      <= req_valid && n_flash;
      rom_ce        <= req_valid && n_rom;
      serial_ce     <= req_valid && n_ser;
    end
  end

  // Registered probe and read results.
  always_ff @(posedge clk) begin
    if (rst) begin
      probe_valid <= 1'b0;
      probe_hit   <= 1'b0;
      probe_index <= '0;
      rd_valid    <= 1'b0;
      rd_vpn2     <= '0;
      rd_asid     <= '0;
      rd_g        <= 1'b0;
      rd_pfn0     <= '0;
      rd_pfn1     <= '0;
      rd_dv0      <= '0;
      rd_dv1      <= '0;
    end else begin
      probe_valid <= probe_req;
      probe_hit   <= probe_req && pr_hit;
      probe_index <= probe_req ? pr_idx : '0;
      rd_valid    <= rd_req;
      if (rd_req && rd_ok) begin
        rd_vpn2 <= e_vpn2[rd_sel];
        rd_asid <= e_asid[rd_sel];
        rd_g    <= e_g[rd_sel];
        rd_pfn0 <= e_pfn0[rd_sel];
        rd_pfn1 <= e_pfn1[rd_sel];
        rd_dv0  <= e_dv0[rd_sel];
        rd_dv1  <= e_dv1[rd_sel];
      end else begin
        rd_vpn2 <= '0;
        rd_asid <= '0;
        rd_g    <= 1'b0;
        rd_pfn0 <= '0;
        rd_pfn1 <= '0;
        rd_dv0  <= '0;
        rd_dv1  <= '0;
      end
    end
  end

endmodule
